// File: rtl/fifo_sync.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync
// Purpose  : Single-clock first-word-fall-through FIFO with valid/ready
//            handshakes on both sides. It buffers words between a producer
//            and a consumer that run on the same clock.
// Ports    : C           - clock, rising edge active
//            R           - asynchronous active-low reset
//            in_data     - write word
//            in_valid    - producer offers in_data
//            in_ready    - FIFO can accept a word (not full)
//            out_data    - head word, meaningful while out_valid=1
//            out_valid   - FIFO holds at least one word
//            out_ready   - consumer takes the head word
//            level       - current occupancy, 0..DEPTH
//            almost_full - level >= AF_LEVEL
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sync #(
  parameter int WIDTH    = 8,
  parameter int AW       = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      level,
  output logic             almost_full
);

  localparam int DEPTH = 1 << AW;

  // Occupancy value meaning "full": only the MSB of the count set.
  localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] AF_COUNT   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  // Storage carries no reset so it can map onto plain RAM/DFF cells.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic push;
  logic pop;

  // Handshake flags are decoded only from the registered count, so there is
  // no combinational path from in_valid/out_ready to in_ready/out_valid.
  assign in_ready    = (count != FULL_COUNT);
  assign out_valid   = (count != '0);
  assign level       = count;
  assign almost_full = (count >= AF_COUNT);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Fall-through read: the head word is visible as soon as it is stored.
  assign out_data = mem[rd_ptr];

  always_ff @(posedge C) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally modulo DEPTH because they are exactly AW bits.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ONE_PTR;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ONE_PTR;
      end
      case ({push, pop})
        2'b10:   count <= count + ONE_COUNT;
        2'b01:   count <= count - ONE_COUNT;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_sync
// Purpose  : Self-checking bench for fifo_sync. A queue-based reference
//            model tracks the expected contents; a compare process checks all
//            outputs every falling edge, and directed steps add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_sync;

  localparam int WIDTH = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;

  logic             C;
  logic             R;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [AW:0]      level;
  logic             almost_full;

  int passed = 0;
  int total  = 0;

  logic [WIDTH-1:0] model_q [$];

  fifo_sync #(.WIDTH(WIDTH), .AW(AW), .AF_LEVEL(AFL)) dut (
    .C           (C),
    .R           (R),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .level       (level),
    .almost_full (almost_full)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a plain queue, full at DEPTH entries, no bypass.
  always @(posedge C or negedge R) begin
    if (!R) begin
      model_q.delete();
    end else begin
      bit do_push;
      bit do_pop;
      do_push = in_valid && (model_q.size() < DEPTH);
      do_pop  = out_ready && (model_q.size() > 0);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(in_data);
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge C) begin
    int sz;
    sz = model_q.size();
    chk("level", 32'(level), 32'(sz));
    chk("in_ready", 32'(in_ready), 32'(sz != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(sz != 0));
    chk("almost_full", 32'(almost_full), 32'(sz >= AFL));
    if (sz > 0) chk("out_data", 32'(out_data), 32'(model_q[0]));
  end

  // Apply inputs for one clock edge; returns 1 time unit after that edge.
  task automatic drive(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge C);
    #1;
  endtask

  initial begin
    // Reset / idle: offered word during reset must not be stored.
    R = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
    repeat (3) @(posedge C);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    R = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    @(posedge C); #1;
    chk("idle_level", 32'(level), 32'd0);

    // Fill with 0x00..0x0F, consumer stalled.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      chk("fill_level", 32'(level), 32'(i + 1));
      if (i == 10) chk("af_below", 32'(almost_full), 32'd0);
      if (i == 11) chk("af_at12", 32'(almost_full), 32'd1);
    end
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 8'hFF, 1'b0);
    chk("full_no_store", 32'(level), 32'd16);

    // Drain in order.
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 32'(out_data), 32'(i));
      drive(1'b0, 8'h00, 1'b1);
    end
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_level", 32'(level), 32'd0);

    // Simultaneous push/pop at level 5 across two pointer wraps.
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h10 + 8'(i), 1'b0);
    chk("pp_start_level", 32'(level), 32'd5);
    for (int i = 0; i < 40; i++) begin
      if (i < 5) chk("pp_head", 32'(out_data), 32'h10 + 32'(i));
      else       chk("pp_head", 32'(out_data), 32'h20 + 32'(i - 5));
      drive(1'b1, 8'h20 + 8'(i), 1'b1);
      chk("pp_level", 32'(level), 32'd5);
    end

    // Top up to full, then push+pop at full: only the pop happens.
    for (int i = 0; i < 11; i++) drive(1'b1, 8'h80 + 8'(i), 1'b0);
    chk("fb_level16", 32'(level), 32'd16);
    drive(1'b1, 8'hC0, 1'b1);
    chk("fb_level15", 32'(level), 32'd15);
    chk("fb_in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 8'hC0, 1'b0);
    chk("fb_accepted", 32'(level), 32'd16);
    for (int i = 0; i < 15; i++) drive(1'b0, 8'h00, 1'b1);
    chk("fb_last_word", 32'(out_data), 32'hC0);
    drive(1'b0, 8'h00, 1'b1);
    chk("fb_empty", 32'(level), 32'd0);

    // Empty boundary: no forwarding in the push cycle.
    out_ready = 1'b1;
    chk("eb_before", 32'(out_valid), 32'd0);
    drive(1'b1, 8'h5A, 1'b1);
    chk("eb_valid", 32'(out_valid), 32'd1);
    chk("eb_data", 32'(out_data), 32'h5A);
    drive(1'b0, 8'h00, 1'b1);
    chk("eb_popped", 32'(level), 32'd0);

    // Reset mid-operation at level 9.
    for (int i = 0; i < 9; i++) drive(1'b1, 8'h60 + 8'(i), 1'b0);
    chk("mr_level9", 32'(level), 32'd9);
    in_valid = 1'b0;
    R = 1'b0;
    #1;
    chk("mr_level", 32'(level), 32'd0);
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    #1;
    R = 1'b1;
    @(posedge C); #1;
    drive(1'b1, 8'h33, 1'b0);
    chk("mr_first_word", 32'(out_data), 32'h33);
    drive(1'b0, 8'h00, 1'b1);
    chk("mr_final_level", 32'(level), 32'd0);

    @(posedge C); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
